apb_slave_regs: RTL and testbench
=================================

# apb_slave_regs

Parametrised APB slave endpoint: a protocol FSM with programmable wait states, error signalling and a small byte-strobed register bank. It generalises the fixed IDLE/SETUP/ENABLE APB state machine. Added behaviour: configurable data/address width and register count, 0..2^WAIT_W-1 wait states per transfer, PSLVERR, and PSTRB write masking. It sits behind the APB decoder as the register front-end for GPIO-class peripherals.

## Interface
- ADDR_W, 8, byte-address width; register index = PADDR[ADDR_W-1:2]
- DATA_W, 32, data width; must be a multiple of 8
- NUM_REGS, 8, registers in the bank; must be at least 2 and at most 2^(ADDR_W-2)
- WAIT_W, 4, width of the wait-state configuration
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0; truncated or zero-extended to DATA_W

- PCLK  in  1  sole clock, rising edge
- PRESETn  in  1  reset, synchronous, active-low
- PSEL  in  1  slave select
- PENABLE  in  1  access-phase strobe
- PWRITE  in  1  1 = write
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PSTRB  in  DATA_W/8  write byte enables
- wait_cfg  in  WAIT_W  wait states to insert; sampled at setup capture
- PRDATA  out  DATA_W  read data; valid only while PREADY=1
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error response; valid only while PREADY=1
- regs_o  out  NUM_REGS*DATA_W  flattened bank; register i at bits [i*DATA_W +: DATA_W]
- xfer_done  out  1  one-cycle pulse on the cycle after any completed transfer

## Operation
- States: IDLE, ACCESS.
- IDLE:
  - On an edge sampling PSEL=1, PENABLE=0 (setup phase), capture PADDR, PWRITE, PWDATA and PSTRB.
  - Load cnt <= wait_cfg and go to ACCESS.
  - Any other input: stay in IDLE.
- ACCESS with PSEL=1, PENABLE=1:
  - PREADY = (cnt==0), combinational from registered state.
  - If cnt!=0: cnt decrements and the state holds.
  - If cnt==0: the transfer commits on this edge and the state goes to IDLE.
- ACCESS with PSEL=1, PENABLE=0: treated as a new setup phase. Recapture all setup inputs, reload cnt, stay in ACCESS; nothing commits.
- ACCESS with PSEL=0: abort to IDLE with no commit and no xfer_done.
- Error condition err is computed from the captured address and direction. err=1 if any of:
  - addr[1:0] != 0 (misaligned)
  - index >= NUM_REGS
  - write to index 0
- Write commit (PWRITE=1, err=0): each byte lane b with PSTRB[b]=1 is updated from PWDATA. Lanes with PSTRB[b]=0 keep their value.
- Read: PRDATA = register[index] when PREADY=1 and err=0. Otherwise PRDATA=0.
- PSLVERR = PREADY & err. An errored write changes no state.
- Register 0 always reads ID_VALUE. Registers 1..NUM_REGS-1 are read/write.

## Timing
- Reset (PRESETn=0 at an edge):
  - state=IDLE, cnt=0
  - registers 1..NUM_REGS-1 = 0
  - PREADY=0, PSLVERR=0, PRDATA=0, xfer_done=0
- Reset asserted mid-transfer: the transfer is dropped with no commit.
- Latency: with wait_cfg=N, PREADY rises in the (N+1)th cycle of the access phase. For example, N=0 gives a zero-wait APB transfer (setup + 1 access cycle).
- Back-to-back transfers: after completion the FSM is in IDLE during the master's next setup cycle, so there are no idle bus cycles between transfers.
- A write is visible on regs_o and on a read in the cycle after its commit edge.
- wait_cfg changes during ACCESS have no effect on the current transfer.
- wait_cfg = 2^WAIT_W-1: counter reaches 0 without wrap; no overflow.
- xfer_done is registered: high for exactly one cycle after each PREADY=1 edge, including errored transfers.

## Structure
- Package apb_slave_pkg holds:
  - state enum {IDLE, ACCESS}
  - REG_ID_IDX = 0
  - a function computing err from address/write/NUM_REGS
- Sub-module apb_wait_counter: load, decrement, zero flag; WAIT_W-wide.
- The register bank and read mux stay in the top module.

## Test plan
- Zero-wait write then read: wait_cfg=0, write 32'hDEADBEEF to 0x04 with PSTRB=4'hF, then read 0x04. Required: PREADY in the first access cycle of each; PRDATA=32'hDEADBEEF; regs_o[63:32]=32'hDEADBEEF.
- Wait states: wait_cfg=3, read 0x00. Required: PREADY low for 3 access cycles, high on the 4th; PRDATA=ID_VALUE; PSLVERR=0.
- Errors:
  - write 0x00 -> PSLVERR=1, register 0 unchanged
  - read 0x20 with NUM_REGS=8 -> PSLVERR=1, PRDATA=0
  - write 0x05 -> PSLVERR=1, no register change
- Strobes: reg1=32'h11223344, write 32'hAABBCCDD with PSTRB=4'b0101. Required: reg1=32'h11BB33DD.
- Abort and reset:
  - PSEL drops during waits (wait_cfg=5) -> no commit, no xfer_done, state IDLE
  - PRESETn=0 mid-access -> all outputs 0 next cycle, bank cleared

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register slave.
// Holds the protocol state encoding and the transfer error rule.
package apb_slave_pkg;

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

    localparam int unsigned REG_ID_IDX = 0;

    // Misaligned, out-of-range, or a write to the read-only ID register.
    function automatic logic calc_err(input logic [1:0]  addr_lo,
                                      input int unsigned idx,
                                      input logic        write,
                                      input int unsigned num_regs);
        return (addr_lo != 2'b00) || (idx >= num_regs) || (write && (idx == REG_ID_IDX));
    endfunction

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between a master and the register slave.
interface apb_slave_regs_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: loads on setup, decrements in access, saturates at zero.
module apb_wait_counter #(
    parameter int unsigned WAIT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic [WAIT_W-1:0] cnt_o,
    output logic              zero_o
);

    logic [WAIT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave endpoint: IDLE/ACCESS protocol FSM with programmable wait states,
// PSLVERR signalling and a byte-strobed register bank with a constant ID register.
module apb_slave_regs
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned WAIT_W   = 4,
    parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    apb_slave_regs_if.slave              apb,
    input  logic [WAIT_W-1:0]            wait_cfg,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         xfer_done
);

    localparam int unsigned StrbW = DATA_W / 8;

    state_e              state_d, state_q;
    logic [ADDR_W-1:0]   addr_d, addr_q;
    logic                write_d, write_q;
    logic [DATA_W-1:0]   wdata_d, wdata_q;
    logic [StrbW-1:0]    strb_d, strb_q;
    logic                xfer_done_d, xfer_done_q;
    logic [DATA_W-1:0]   bank_d [NUM_REGS];
    logic [DATA_W-1:0]   bank_q [NUM_REGS];

    logic                setup, access, in_access;
    logic                cnt_zero, pready, err;
    logic [WAIT_W-1:0]   cnt_unused;
    int unsigned         idx;
    logic [DATA_W-1:0]   id_val, rdata;

    assign id_val    = DATA_W'(ID_VALUE);
    assign setup     = apb.PSEL & ~apb.PENABLE;
    assign access    = apb.PSEL & apb.PENABLE;
    assign in_access = (state_q == StAccess);
    assign idx       = 32'(addr_q[ADDR_W-1:2]);
    assign err       = calc_err(addr_q[1:0], idx, write_q, NUM_REGS);
    assign pready    = in_access & access & cnt_zero;

    // Any setup phase reloads, whether from IDLE or a re-setup inside ACCESS.
    apb_wait_counter #(
        .WAIT_W (WAIT_W)
    ) u_wait_counter (
        .clk_i      (PCLK),
        .rst_ni     (PRESETn),
        .load_i     (setup),
        .load_val_i (wait_cfg),
        .dec_i      (in_access & access),
        .cnt_o      (cnt_unused),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        xfer_done_d = pready;

        if (setup) begin
            addr_d  = apb.PADDR;
            write_d = apb.PWRITE;
            wdata_d = apb.PWDATA;
            strb_d  = apb.PSTRB;
        end

        unique case (state_q)
            StIdle: begin
                if (setup) state_d = StAccess;
            end
            StAccess: begin
                if (!apb.PSEL) begin
                    state_d = StIdle;
                end else if (setup) begin
                    state_d = StAccess;
                end else if (cnt_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bank_d = bank_q;
        if (pready && write_q && !err) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (idx == i) begin
                    for (int unsigned b = 0; b < StrbW; b++) begin
                        if (strb_q[b]) bank_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (pready && !write_q && !err) begin
            if (idx == REG_ID_IDX) begin
                rdata = id_val;
            end else begin
                for (int unsigned i = 1; i < NUM_REGS; i++) begin
                    if (idx == i) rdata = bank_q[i];
                end
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_o[i*DATA_W +: DATA_W] = (i == REG_ID_IDX) ? id_val : bank_q[i];
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            xfer_done_q <= 1'b0;
            bank_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            xfer_done_q <= xfer_done_d;
            bank_q      <= bank_d;
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = pready;
    assign apb.PSLVERR = pready & err;
    assign xfer_done   = xfer_done_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: transfers, wait states, errors, strobes,
// abort and mid-access reset against a hand-maintained register model.
module tb_apb_slave_regs;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned WAIT_W   = 4;
    localparam logic [31:0] ID       = 32'hA5B0_0001;

    logic                       clk;
    logic                       rst_n;
    logic [WAIT_W-1:0]          wait_cfg;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic                       xfer_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [NUM_REGS];
    logic [31:0] rdata;
    logic        slverr;
    logic        xd;
    int          waits;
    logic        seen_ready;

    apb_slave_regs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_slave_regs #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .WAIT_W   (WAIT_W),
        .ID_VALUE (ID)
    ) dut (
        .PCLK      (clk),
        .PRESETn   (rst_n),
        .apb       (apb.slave),
        .wait_cfg  (wait_cfg),
        .regs_o    (regs),
        .xfer_done (xfer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] packed_model();
        logic [NUM_REGS*DATA_W-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = model[i];
        return v;
    endfunction

    // Full transfer: setup, access until PREADY (bounded), then the xfer_done cycle.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] wc, input logic [3:0] wc_acc,
                        output logic [31:0] rd, output logic se, output int nw,
                        output logic done);
        @(negedge clk);
        wait_cfg = wc;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = w;
        apb.PADDR = a; apb.PWDATA = d; apb.PSTRB = s;
        @(negedge clk);
        apb.PENABLE = 1'b1;
        wait_cfg = wc_acc;
        #1;
        nw = 0;
        while (!apb.PREADY && nw < 64) begin
            @(negedge clk); #1;
            nw++;
        end
        rd = apb.PRDATA;
        se = apb.PSLVERR;
        @(negedge clk);
        done = xfer_done;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0; apb.PSTRB = '0;
        wait_cfg = '0;
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        model[0] = ID;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pready", 256'(apb.PREADY), 256'(1'b0));
        chk("rst_pslverr", 256'(apb.PSLVERR), 256'(1'b0));
        chk("rst_prdata", 256'(apb.PRDATA), 256'(32'h0));
        chk("rst_xfer_done", 256'(xfer_done), 256'(1'b0));
        chk("rst_regs", 256'(regs), 256'(packed_model()));
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait write then read
        xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 4'd0, 4'd0, rdata, slverr, waits, xd);
        model[1] = 32'hDEADBEEF;
        chk("w0_waits", 256'(waits), 256'(0));
        chk("w0_slverr", 256'(slverr), 256'(1'b0));
        chk("w0_xfer_done", 256'(xd), 256'(1'b1));
        chk("w0_reg1", 256'(regs[63:32]), 256'(32'hDEADBEEF));
        xfer(1'b0, 8'h04, 32'h0, 4'h0, 4'd0, 4'd0, rdata, slverr, waits, xd);
        chk("r0_waits", 256'(waits), 256'(0));
        chk("r0_data", 256'(rdata), 256'(32'hDEADBEEF));

        // Three wait states reading the ID register
        xfer(1'b0, 8'h00, 32'h0, 4'h0, 4'd3, 4'd3, rdata, slverr, waits, xd);
        chk("w3_waits", 256'(waits), 256'(3));
        chk("w3_id", 256'(rdata), 256'(ID));
        chk("w3_slverr", 256'(slverr), 256'(1'b0));

        // Error cases
        xfer(1'b1, 8'h00, 32'h12345678, 4'hF, 4'd0, 4'd0, rdata, slverr, waits, xd);
        chk("err_wr_id_slverr", 256'(slverr), 256'(1'b1));
        chk("err_wr_id_done", 256'(xd), 256'(1'b1));
        chk("err_wr_id_regs", 256'(regs), 256'(packed_model()));
        xfer(1'b0, 8'h20, 32'h0, 4'h0, 4'd0, 4'd0, rdata, slverr, waits, xd);
        chk("err_rd_oob_slverr", 256'(slverr), 256'(1'b1));
        chk("err_rd_oob_data", 256'(rdata), 256'(32'h0));
        xfer(1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 4'd0, 4'd0, rdata, slverr, waits, xd);
        chk("err_wr_mis_slverr", 256'(slverr), 256'(1'b1));
        chk("err_wr_mis_regs", 256'(regs), 256'(packed_model()));

        // Byte strobes
        xfer(1'b1, 8'h04, 32'h11223344, 4'hF, 4'd0, 4'd0, rdata, slverr, waits, xd);
        xfer(1'b1, 8'h04, 32'hAABBCCDD, 4'b0101, 4'd0, 4'd0, rdata, slverr, waits, xd);
        model[1] = 32'h11BB33DD;
        chk("strb_regs", 256'(regs), 256'(packed_model()));
        xfer(1'b0, 8'h04, 32'h0, 4'h0, 4'd1, 4'd1, rdata, slverr, waits, xd);
        chk("strb_read", 256'(rdata), 256'(32'h11BB33DD));
        chk("strb_read_waits", 256'(waits), 256'(1));

        // wait_cfg changed during access is ignored; maximum wait count
        xfer(1'b1, 8'h1C, 32'h0BADF00D, 4'hF, 4'd2, 4'd7, rdata, slverr, waits, xd);
        model[7] = 32'h0BADF00D;
        chk("wcfg_change_waits", 256'(waits), 256'(2));
        chk("wcfg_change_regs", 256'(regs), 256'(packed_model()));
        xfer(1'b0, 8'h1C, 32'h0, 4'h0, 4'd15, 4'd15, rdata, slverr, waits, xd);
        chk("wmax_waits", 256'(waits), 256'(15));
        chk("wmax_data", 256'(rdata), 256'(32'h0BADF00D));

        // Abort: PSEL drops during wait states
        @(negedge clk);
        wait_cfg = 4'd5;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 8'h08; apb.PWDATA = 32'h12345678; apb.PSTRB = 4'hF;
        @(negedge clk);
        apb.PENABLE = 1'b1;
        @(negedge clk); #1;
        chk("abort_pready", 256'(apb.PREADY), 256'(1'b0));
        @(negedge clk);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        @(negedge clk);
        chk("abort_done_a", 256'(xfer_done), 256'(1'b0));
        @(negedge clk);
        chk("abort_done_b", 256'(xfer_done), 256'(1'b0));
        chk("abort_regs", 256'(regs), 256'(packed_model()));
        // Access strobe without setup must never complete from IDLE
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1;
        seen_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (apb.PREADY) seen_ready = 1'b1;
            @(negedge clk);
        end
        chk("abort_idle", 256'(seen_ready), 256'(1'b0));
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;

        // Reset mid-access
        xfer(1'b1, 8'h14, 32'hCAFEF00D, 4'hF, 4'd0, 4'd0, rdata, slverr, waits, xd);
        model[5] = 32'hCAFEF00D;
        chk("pre_rst_regs", 256'(regs), 256'(packed_model()));
        @(negedge clk);
        wait_cfg = 4'd4;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = 8'h14; apb.PSTRB = 4'h0;
        @(negedge clk);
        apb.PENABLE = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        for (int i = 1; i < NUM_REGS; i++) model[i] = '0;
        chk("mid_rst_pready", 256'(apb.PREADY), 256'(1'b0));
        chk("mid_rst_pslverr", 256'(apb.PSLVERR), 256'(1'b0));
        chk("mid_rst_prdata", 256'(apb.PRDATA), 256'(32'h0));
        chk("mid_rst_done", 256'(xfer_done), 256'(1'b0));
        chk("mid_rst_regs", 256'(regs), 256'(packed_model()));
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        rst_n = 1'b1;
        xfer(1'b0, 8'h14, 32'h0, 4'h0, 4'd0, 4'd0, rdata, slverr, waits, xd);
        chk("post_rst_read", 256'(rdata), 256'(32'h0));
        chk("post_rst_waits", 256'(waits), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
